// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, SETUP/ACCESS out,
// one registered response pulse per transfer with slave-error and timeout status.
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      last_access;

    // cnt_q holds completed wait cycles, so cnt_q+1 is the current ACCESS cycle number.
    assign last_access = (TIMEOUT_CYCLES > 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : 32'd0;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : 32'd0;
                end else if (last_access) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = 32'd0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 4-cycle ACCESS timeout.
module tb_apb_master_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL rst_psel got %b%b exp 00", PSEL, PENABLE); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp got %b%b%b exp 000", rsp_valid, rsp_err, rsp_timeout); end
        checks++; if (PADDR !== 12'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_regs got %h %h %b %h exp 0", PADDR, PWDATA, PWRITE, rsp_rdata); end
        tick();
        HRESET = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_zero_wait_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h008; req_wdata = 32'hDEADBEEF; PREADY = 1'b1;
        tick();
        req_valid = 1'b0; req_wdata = 32'h0;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin errors++; $display("FAIL wr_setup got %b%b exp 10", PSEL, PENABLE); end
        checks++; if (PADDR !== 12'h008 || PWRITE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_addr got %h %b %h exp 008 1 deadbeef", PADDR, PWRITE, PWDATA); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy got %b exp 0", req_ready); end
        tick();
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_access got %b%b %h exp 11 deadbeef", PSEL, PENABLE, PWDATA); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_early_rsp got %b exp 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp got %b%b%b %h exp 100 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        checks++; if (PSEL !== 1'b0 || PWDATA !== 32'hDEADBEEF || PADDR !== 12'h008) begin errors++; $display("FAIL wr_idle_hold got %b %h %h exp 0 deadbeef 008", PSEL, PWDATA, PADDR); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b exp 0", rsp_valid); end
    endtask

    task automatic test_wait_read();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h1A4; PREADY = 1'b0; PRDATA = 32'hFFFF0000;
        tick();
        req_valid = 1'b0; req_addr = 12'h000;
        checks++; if (PWDATA !== 32'h0 || PWRITE !== 1'b0) begin errors++; $display("FAIL rd_pwdata got %h %b exp 0 0", PWDATA, PWRITE); end
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin PREADY = 1'b1; PRDATA = 32'h12345678; end
            checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 12'h1A4 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access%0d got %b%b %h %b exp 11 1a4 0", k, PSEL, PENABLE, PADDR, rsp_valid); end
            tick();
        end
        PREADY = 1'b0; PRDATA = 32'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rd_rsp got %b %h %b%b exp 1 12345678 00", rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_hold got %b %h exp 0 12345678", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_slave_error();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h0F0; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hAAAA5555;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        PSLVERR = 1'b0;
        chk("err_valid", {31'd0, rsp_valid}, 32'd1);
        chk("err_err", {31'd0, rsp_err}, 32'd1);
        chk("err_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("err_rdata", rsp_rdata, 32'h0);
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h200; PREADY = 1'b0; PRDATA = 32'h5A5A5A5A;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_access%0d got %b%b %b exp 11 0", k, PSEL, PENABLE, rsp_valid); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp got %b%b%b %h exp 111 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL to_idle got %b%b %b exp 00 1", PSEL, PENABLE, req_ready); end
        // PREADY arrives in the last allowed ACCESS cycle: completion wins.
        req_valid = 1'b1; req_addr = 12'h204;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin PREADY = 1'b1; PRDATA = 32'hCAFEF00D; end
            tick();
        end
        PREADY = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL to_edge got %b%b%b %h exp 100 cafef00d", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h010; PREADY = 1'b1; PRDATA = 32'h11111111;
        tick();
        req_addr = 12'h014;
        checks++; if (req_ready !== 1'b0 || PSEL !== 1'b1 || PADDR !== 12'h010) begin errors++; $display("FAIL b2b_setup_a got %b %b %h exp 0 1 010", req_ready, PSEL, PADDR); end
        tick();
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL b2b_access_a got %b%b exp 11", PSEL, PENABLE); end
        tick();
        PRDATA = 32'h22222222;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111 || req_ready !== 1'b1 || PSEL !== 1'b0) begin errors++; $display("FAIL b2b_rsp_a got %b %h %b %b exp 1 11111111 1 0", rsp_valid, rsp_rdata, req_ready, PSEL); end
        tick();
        req_valid = 1'b0;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 12'h014 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_setup_b got %b%b %h %b exp 10 014 0", PSEL, PENABLE, PADDR, rsp_valid); end
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_rsp_b got %b %h exp 1 22222222", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h300; req_wdata = 32'h0BADF00D; PREADY = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL mr_in_access got %b exp 1", PENABLE); end
        #2 HRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL mr_async got %b%b exp 00", PSEL, PENABLE); end
        @(negedge HCLK);
        HRESET = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL mr_release got %b %b %b exp 1 0 0", req_ready, rsp_valid, PSEL); end
        PREADY = 1'b1; PRDATA = 32'h87654321;
        for (int k = 0; k < 3; k++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_no_rsp%0d got %b exp 0", k, rsp_valid); end
            tick();
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h304;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h87654321 || rsp_err !== 1'b0) begin errors++; $display("FAIL mr_next got %b %h %b exp 1 87654321 0", rsp_valid, rsp_rdata, rsp_err); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB3 initiator that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward peripheral slaves such as the GPIO and timer blocks. It supports slave wait states via PREADY, captures PSLVERR, and aborts hung transfers with a programmable timeout. Each transfer returns one response pulse carrying read data and error status. It sits between the SoC-side control logic and the APB peripheral address space.

Parameters:
APB_ADDR_WIDTH, 12, width of req_addr and PADDR (4KB slave space).
TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  reset, asynchronous, active-high
req_valid  in  1  command request
req_ready  out  1  bridge can accept a command
req_write  in  1  1=write, 0=read
req_addr  in  APB_ADDR_WIDTH  byte address
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data; 0 for writes, errors and timeouts
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB slave ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clock is HCLK. Reset is HRESET, asynchronous and active-high.
- Reset values: state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_* and the timeout counter are all 0. req_ready is 1 once HRESET deasserts.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except req_ready, which is (state==IDLE).
- IDLE:
  - PSEL=0, PENABLE=0.
  - On req_valid && req_ready, latch PADDR=req_addr, PWRITE=req_write, PWDATA=(req_write ? req_wdata : 0), then go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - The timeout counter increments every ACCESS cycle.
  - Complete when PREADY=1: go to IDLE.
  - Response: in the following cycle rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0.
  - rsp_rdata=PRDATA only for a read with PSLVERR=0; otherwise 0.
- Timeout (TIMEOUT_CYCLES>0):
  - If PREADY=0 in the TIMEOUT_CYCLES-th ACCESS cycle (counted from 1), abort.
  - On abort: go to IDLE, then rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in that same cycle is a normal completion; PREADY wins over the timeout.
  - The counter clears on entry to SETUP. Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- TIMEOUT_CYCLES=0: ACCESS waits indefinitely for PREADY.
- Response timing:
  - rsp_valid is a single-cycle pulse with no back-pressure.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response; they are meaningful only while rsp_valid=1.
- Latency: accept in cycle N, SETUP in N+1, first ACCESS in N+2, response in N+2+W+1, where W is the number of wait states.
- Back-to-back: a new command may be accepted in the IDLE cycle where rsp_valid=1. PSEL is therefore low for exactly 1 cycle between consecutive transfers.
- PADDR, PWRITE and PWDATA retain their last values in IDLE (no toggling).
- PSLVERR is sampled only when PSEL && PENABLE && PREADY. PRDATA is ignored otherwise.
- Reset mid-transfer:
  - PSEL and PENABLE drop asynchronously.
  - The in-flight transfer is discarded and no rsp_valid is generated.
  - After release the bridge is in IDLE with req_ready=1.

Test Plan:
- Zero-wait write (req addr 0x008, wdata 0xDEADBEEF, PREADY=1, accept in cycle 0):
  - Required: PSEL=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2.
  - Required: rsp_valid=1, rsp_err=0, rsp_rdata=0 in cycle 3; PWDATA=0xDEADBEEF throughout.
- Read with 3 wait states (PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 with PREADY):
  - Required: ACCESS lasts 4 cycles with PADDR stable.
  - Required: rsp_rdata=0x12345678, rsp_err=0.
- Slave error (read, PSLVERR=1 with PREADY):
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout with TIMEOUT_CYCLES=4:
  - PREADY held low: abort after 4 ACCESS cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 in the 4th ACCESS cycle: normal completion, rsp_timeout=0.
- Back-to-back (req_valid held for two reads, PREADY=1):
  - Required: second command accepted in the rsp_valid cycle of the first.
  - Required: PSEL low exactly 1 cycle between transfers; 3 cycles per transfer.
- Reset during ACCESS (HRESET pulsed while PREADY=0):
  - Required: PSEL=PENABLE=0 immediately and no rsp_valid.
  - Required: req_ready=1 in the first cycle after release; the next command completes normally.
